btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
- Input-conditioning stage that sits directly upstream of the computer's PORTI/PORTJ inputs.
- Takes raw asynchronous button/switch levels and synchronizes them to clk, then debounces them on a shared sample tick.
- Delivers a clean level word plus one-clock rise/fall pulses and sticky "pressed" flags, so CPU software reads stable values.

Parameters:
- WIDTH, 32, number of input bits, matching the CPU port width.
- DIV, 1000, clk cycles per debounce sample tick; must be >= 1.
- DIVW, 16, prescaler counter width; must satisfy 2^DIVW >= DIV.
- SAMPLES, 4, consecutive equal samples required to accept a new level; must be >= 2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- din  input  WIDTH  raw asynchronous button/switch levels.
- clr  input  WIDTH  per-bit clear strobe for pressed.
- dout  output  WIDTH  debounced level; feeds PORTI/PORTJ.
- rise  output  WIDTH  one-clk pulse when dout bit goes 0->1.
- fall  output  WIDTH  one-clk pulse when dout bit goes 1->0.
- pressed  output  WIDTH  sticky flag per bit, set by rise.
- tick  output  1  one-clk sample strobe, for observation.

Behaviour:
- Reset (reset=0, asynchronous) clears the synchronizer flops, the history registers, dout, rise, fall, pressed, tick, and the prescaler. Everything is held at 0 until reset=1.
- Synchronizer: two flops per bit (s1<=din, s2<=s1). No other logic reads din.
- Prescaler counts 0..DIV-1 and wraps to 0.
  - tick=1 (registered) for exactly the one clk in which the count equals DIV-1; otherwise 0.
  - With DIV=1, tick is 1 in every cycle after reset.
- On each tick, every bit shifts s2 into a SAMPLES-bit history register.
  - Next history all 1s: dout bit <= 1.
  - Next history all 0s: dout bit <= 0.
  - Mixed: dout bit holds.
- Latency: a stable din change appears on dout after 2 clks plus SAMPLES ticks.
  - With DIV=1 and SAMPLES=4, dout changes on the 6th rising edge after din changes.
- A pulse or glitch on din shorter than SAMPLES ticks after synchronization never changes dout.
- rise/fall are registered in the same edge as dout: rise=new&~old, fall=~new&old. They are high for exactly one clk and never high together for the same bit.
- pressed bit:
  - Set by rise.
  - Cleared by the clr bit, sampled at the clock edge.
  - If rise and clr occur in the same cycle, set wins so no press is lost.
  - If clr is held high continuously, pressed stays 0 except in the cycle following a rise.
- Bits are fully independent; the prescaler/tick is shared by all bits.
- Reset asserted mid-debounce discards partial history. After release, inputs already high need the full latency again before dout rises.
- No combinational path from din or clr to any output; all outputs are registered.

Optional Feature:
- Macro BTNC_IRQ_EN.
- When defined:
  - Adds input ie[WIDTH] (interrupt enable mask).
  - Adds output irq (1 bit), registered, irq <= |(pressed_next & ie).
  - irq reset value is 0.
  - irq stays high while any enabled pressed flag is set, and drops the clk after the last such flag is cleared or its ie bit is cleared.
- When undefined: ie and irq do not exist, and there is no other behavioural change.

Test Plan:
- DIV=1, SAMPLES=4, reset=0 for 5 clks with din=32'hFFFFFFFF -> all outputs 0 during reset. After release, dout=32'hFFFFFFFF on the 6th edge, rise=32'hFFFFFFFF for that one clk, pressed=32'hFFFFFFFF.
- DIV=1: din[2]=1 held -> dout[2]=1 on the 6th edge, rise[2]=1 for one clk. Then din[2]=0 -> dout[2]=0 six edges later, fall[2]=1 for one clk, pressed[2] stays 1.
- DIV=1: din[0] high for 3 clks then low -> dout[0], rise[0] and pressed[0] remain 0 throughout.
- DIV=4: tick period is exactly 4 clks. din[5]=1 -> dout[5] rises within 2+4*4 to 2+4*4+3 clks.
- pressed[3]=1; assert clr[3]=1 for one clk -> pressed[3]=0 next edge. Assert clr[3] in the same cycle as a new rise[3] -> pressed[3] remains 1.
- With BTNC_IRQ_EN: ie=32'h4, pressed[2] set -> irq=1. Clear pressed[2] -> irq=0 one clk later. pressed[7] set with ie[7]=0 -> irq stays 0.

Source files
------------

// File: rtl/btn_conditioner_if.sv
// Interface bundling the data/strobe signals of btn_conditioner.
// The conditioner uses the slave modport; the consumer of the conditioned
// levels (CPU port logic or a bench) uses the master modport.
// With BTNC_IRQ_EN defined, the bundle also carries the ie mask and irq line.
interface btn_conditioner_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] pressed;
    logic             tick;
`ifdef BTNC_IRQ_EN
    logic [WIDTH-1:0] ie;
    logic             irq;
`endif

    modport master (
        output din, clr,
`ifdef BTNC_IRQ_EN
        output ie,
        input  irq,
`endif
        input  dout, rise, fall, pressed, tick
    );

    modport slave (
        input  din, clr,
`ifdef BTNC_IRQ_EN
        input  ie,
        output irq,
`endif
        output dout, rise, fall, pressed, tick
    );
endinterface

// File: rtl/btn_conditioner.sv
// Button/switch input conditioner feeding the CPU PORTI/PORTJ inputs.
// Raw levels pass through a two-flop synchronizer, then are debounced on a
// shared prescaler tick: a bit's output level only changes once SAMPLES
// consecutive tick samples agree. Outputs: clean level, one-clock rise/fall
// pulses and sticky pressed flags (set wins over a simultaneous clear).
// Optional: define BTNC_IRQ_EN to add the ie mask input and irq output.
module btn_conditioner #(
    parameter int WIDTH   = 32,
    parameter int DIV     = 1000,
    parameter int DIVW    = 16,
    parameter int SAMPLES = 4
) (
    input logic               clk,
    input logic               reset,
    btn_conditioner_if.slave  bus
);

    logic [WIDTH-1:0]              s1_q, s1_d;
    logic [WIDTH-1:0]              s2_q, s2_d;
    logic [DIVW-1:0]               cnt_q, cnt_d;
    logic                          tick_q, tick_d;
    logic [WIDTH-1:0][SAMPLES-1:0] hist_q, hist_d;
    logic [WIDTH-1:0]              dout_q, dout_d;
    logic [WIDTH-1:0]              rise_q, rise_d;
    logic [WIDTH-1:0]              fall_q, fall_d;
    logic [WIDTH-1:0]              pressed_q, pressed_d;
`ifdef BTNC_IRQ_EN
    logic                          irq_q, irq_d;
`endif

    // Synchronizer stages and prescaler; tick is registered so it is high
    // exactly in the cycle where the counter sits at DIV-1.
    always_comb begin
        s1_d   = bus.din;
        s2_d   = s1_q;
        cnt_d  = (cnt_q == DIVW'(DIV - 1)) ? '0 : cnt_q + DIVW'(1);
        tick_d = (cnt_d == DIVW'(DIV - 1));
    end

    // Per-bit history shift on tick; output level only moves on a unanimous history.
    always_comb begin
        hist_d = hist_q;
        dout_d = dout_q;
        if (tick_q) begin
            for (int i = 0; i < WIDTH; i++) begin
                hist_d[i] = {hist_q[i][SAMPLES-2:0], s2_q[i]};
                if (&hist_d[i]) begin
                    dout_d[i] = 1'b1;
                end else if (~|hist_d[i]) begin
                    dout_d[i] = 1'b0;
                end
            end
        end
    end

    // Edge pulses share the dout edge; a rise in the same cycle as clr keeps the press.
    always_comb begin
        rise_d    = dout_d & ~dout_q;
        fall_d    = ~dout_d & dout_q;
        pressed_d = (pressed_q & ~bus.clr) | rise_d;
`ifdef BTNC_IRQ_EN
        irq_d     = |(pressed_d & bus.ie);
`endif
    end

    // State registers; reset discards all partial debounce history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            hist_q    <= '0;
            dout_q    <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            pressed_q <= '0;
`ifdef BTNC_IRQ_EN
            irq_q     <= 1'b0;
`endif
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            hist_q    <= hist_d;
            dout_q    <= dout_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            pressed_q <= pressed_d;
`ifdef BTNC_IRQ_EN
            irq_q     <= irq_d;
`endif
        end
    end

    assign bus.dout    = dout_q;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;
    assign bus.pressed = pressed_q;
    assign bus.tick    = tick_q;
`ifdef BTNC_IRQ_EN
    assign bus.irq     = irq_q;
`endif

endmodule
